// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2, one iteration per clock, start/busy/done handshake.
// Optional `MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies finish at acceptance.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd,
   output logic            busy,
   output logic            done,
   output logic            wb_we,
   output logic [4:0]      wb_addr,
   output logic [XLEN-1:0] wb_data
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [5:0]      LAST    = 6'(XLEN - 1);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t              r_state, w_state_next;
   logic [5:0]          r_cnt;
   logic [2:0]          r_funct3;
   logic [4:0]          r_rd;
   logic [XLEN-1:0]     r_b;
   logic [2*XLEN-1:0]   r_acc;
   logic                r_neg_q, r_neg_r, r_div0, r_ovf;
   logic [XLEN-1:0]     r_wb_data;

   logic                w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
   logic [XLEN-1:0]     w_mag_a, w_mag_b;
   logic                w_div0, w_ovf, w_accept;
   logic                w_early;
   logic [XLEN-1:0]     w_early_data;
   logic [XLEN:0]       w_sum, w_diff;
   logic [2*XLEN-1:0]   w_acc_step, w_prod;
   logic [XLEN-1:0]     w_quot, w_rem, w_result;

   // Operand decode on the raw inputs; only meaningful on the acceptance edge.
   assign w_is_div = funct3[2];
   assign w_sgn_a  = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign w_sgn_b  = w_is_div ? ~funct3[0] : ~funct3[1];
   assign w_neg_a  = w_sgn_a & op_a[XLEN-1];
   assign w_neg_b  = w_sgn_b & op_b[XLEN-1];
   assign w_mag_a  = w_neg_a ? (~op_a + 1'b1) : op_a;
   assign w_mag_b  = w_neg_b ? (~op_b + 1'b1) : op_b;
   assign w_div0   = w_is_div & (op_b == '0);
   assign w_ovf    = w_is_div & ~funct3[0] & (op_a == INT_MIN) & (op_b == '1);
   assign w_accept = (r_state == S_IDLE) & start & ~kill;

`ifdef MULDIV_EARLY_OUT_EN
   assign w_early = w_div0 | w_ovf | (~w_is_div & ((op_a == '0) | (op_b == '0)));

   always_comb begin
      w_early_data = '0;
      if (w_is_div) begin
         if (w_div0)
            w_early_data = funct3[1] ? op_a : '1;
         else
            w_early_data = funct3[1] ? '0 : INT_MIN;
      end
   end
`else
   assign w_early      = 1'b0;
   assign w_early_data = '0;
`endif

   // One iteration: multiply shifts the 64-bit product right, divide shifts {rem, quot} left.
   assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_b : '0)};
   assign w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};

   always_comb begin
      w_acc_step = {w_sum, r_acc[XLEN-1:1]};
      if (r_funct3[2]) begin
         if (w_diff[XLEN])
            w_acc_step = {r_acc[2*XLEN-2:0], 1'b0};
         else
            w_acc_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end
   end

   assign w_prod = r_neg_q ? (~w_acc_step + 1'b1) : w_acc_step;
   assign w_quot = r_neg_q ? (~w_acc_step[XLEN-1:0] + 1'b1) : w_acc_step[XLEN-1:0];
   assign w_rem  = r_neg_r ? (~w_acc_step[2*XLEN-1:XLEN] + 1'b1) : w_acc_step[2*XLEN-1:XLEN];

   // Divide-by-zero remainder already equals op_a from the iteration, so only overflow needs forcing.
   always_comb begin
      w_result = '0;
      case (r_funct3)
         3'b000:                 w_result = w_prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_result = r_div0 ? '1 : (r_ovf ? INT_MIN : w_quot);
         default:                w_result = r_ovf ? '0 : w_rem;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_next = w_early ? S_DONE : S_BUSY;
         S_BUSY: begin
            if (kill)
               w_state_next = S_IDLE;
            else if (r_cnt == LAST)
               w_state_next = S_DONE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_funct3  <= '0;
         r_rd      <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_div0    <= 1'b0;
         r_ovf     <= 1'b0;
         r_wb_data <= '0;
      end else begin
         if (w_accept) begin
            r_funct3 <= funct3;
            r_rd     <= rd;
            r_cnt    <= '0;
            r_b      <= w_is_div ? w_mag_b : w_mag_a;
            r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
            if (w_early)
               r_wb_data <= w_early_data;
         end else if ((r_state == S_BUSY) && !kill) begin
            r_cnt <= r_cnt + 6'd1;
            r_acc <= w_acc_step;
            if (r_cnt == LAST)
               r_wb_data <= w_result;
         end
      end
   end

   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);
   assign wb_we   = done & (r_rd != 5'd0);
   assign wb_addr = r_rd;
   assign wb_data = r_wb_data;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, kill, ignored starts, async reset, rd=0.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [4:0]  rd = '0;
   logic        busy, done, wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .rd(rd), .busy(busy), .done(done),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Issue one op, scramble inputs after acceptance, wait for done and check the write-back.
   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp, input bit eo);
      int  lat;
      bit  seen;
      int  exp_lat;
      exp_lat = (EARLY && eo) ? 1 : 33;
      @(negedge clk);
      start = 1'b1; funct3 = f; op_a = a; op_b = b; rd = r;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 100) begin
         @(negedge clk);
         start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd = 5'($urandom);
         lat++;
         if (lat == 1) check({tag, " busy"}, 32'(busy), 32'd1);
         if (done) seen = 1'b1;
      end
      check({tag, " done_seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " wb_we"}, 32'(wb_we), 32'(r != 5'd0));
      check({tag, " wb_addr"}, 32'(wb_addr), 32'(r));
      check({tag, " wb_data"}, wb_data, exp);
      $display("op %s: f=%0d a=%h b=%h rd=%0d -> data=%h lat=%0d", tag, f, a, b, r, wb_data, lat);
      @(negedge clk);
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
      check({tag, " idle_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      int n_done;
      int n_we;
      int first_lat;
      logic [31:0] got_data;
      logic [4:0]  got_addr;

      repeat (2) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset wb_we", 32'(wb_we), 32'd0);
      check("reset wb_addr", 32'(wb_addr), 32'd0);
      check("reset wb_data", wb_data, 32'd0);
      $display("reset: busy=%0d done=%0d wb_data=%h", busy, done, wb_data);
      rst = 1'b0;

      do_op("MUL",       3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0);
      do_op("MULH",      3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 1'b0);
      do_op("MULHU",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0);
      do_op("MULHSU",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0);
      do_op("DIV",       3'b100, 32'hFFFF_FFF9, 32'd2,        5'd7, 32'hFFFF_FFFD, 1'b0);
      do_op("REM",       3'b110, 32'hFFFF_FFF9, 32'd2,        5'd8, 32'hFFFF_FFFF, 1'b0);
      do_op("DIVU",      3'b101, 32'd100,      32'd7,        5'd9, 32'd14,        1'b0);
      do_op("REMU",      3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        1'b0);
      do_op("DIV0",      3'b100, 32'd9,        32'd0,        5'd11, 32'hFFFF_FFFF, 1'b1);
      do_op("REM0",      3'b110, 32'd9,        32'd0,        5'd12, 32'd9,        1'b1);
      do_op("DIVneg0",   3'b100, 32'hFFFF_FFF9, 32'd0,       5'd13, 32'hFFFF_FFFF, 1'b1);
      do_op("REMneg0",   3'b110, 32'hFFFF_FFF7, 32'd0,       5'd14, 32'hFFFF_FFF7, 1'b1);
      do_op("DIVU0",     3'b101, 32'd9,        32'd0,        5'd15, 32'hFFFF_FFFF, 1'b1);
      do_op("DIVovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1'b1);
      do_op("REMovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,       1'b1);
      do_op("MULzero",   3'b000, 32'd0,        32'd5,        5'd18, 32'd0,        1'b1);
      do_op("MULHU_rd0", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 1'b0);

      // Kill at iteration 10.
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd = 5'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("kill pre_busy", 32'(busy), 32'd1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill busy", 32'(busy), 32'd0);
      check("kill done", 32'(done), 32'd0);
      n_done = 0; n_we = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) n_done++;
         if (wb_we) n_we++;
      end
      check("kill no_done", n_done, 0);
      check("kill no_we", n_we, 0);
      $display("kill: done pulses=%0d we pulses=%0d", n_done, n_we);

      // Start pulses during BUSY and during DONE are ignored.
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd = 5'd3;
      n_done = 0; first_lat = 0; got_data = '0; got_addr = '0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == 5) begin
            start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd = 5'd9;
         end
         if (done) begin
            n_done++;
            if (n_done == 1) begin
               first_lat = i; got_data = wb_data; got_addr = wb_addr;
               start = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd = 5'd9;
            end
         end
      end
      start = 1'b0;
      check("hs completions", n_done, 1);
      check("hs latency", first_lat, 33);
      check("hs wb_data", got_data, 32'd14);
      check("hs wb_addr", 32'(got_addr), 32'd3);
      check("hs idle", 32'(busy), 32'd0);
      $display("handshake: completions=%0d lat=%0d data=%h", n_done, first_lat, got_data);

      // Asynchronous reset mid-BUSY.
      @(negedge clk);
      start = 1'b1; funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd = 5'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check("arst pre_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst busy", 32'(busy), 32'd0);
      check("arst done", 32'(done), 32'd0);
      check("arst wb_we", 32'(wb_we), 32'd0);
      check("arst wb_addr", 32'(wb_addr), 32'd0);
      check("arst wb_data", wb_data, 32'd0);
      $display("async reset: busy=%0d wb_addr=%0d wb_data=%h", busy, wb_addr, wb_data);
      @(negedge clk);
      rst = 1'b0;
      do_op("after_rst", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, located directly downstream of the synchronous-read register file. It consumes the registered read operands (RD1/RD2) together with the destination register index. It produces a write-back triple (enable, address, data) that drives the register file's WE/A3/WD3 port through the write-back mux. Radix-2 serial datapath: one iteration per clock, with a start/busy/done handshake toward the control unit.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- kill  in  1  abort current operation; no write-back.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  32  rs1 value (register file RD1).
- op_b  in  32  rs2 value (register file RD2).
- rd  in  5  destination register index.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- wb_we  out  1  equals done AND (rd_q != 0).
- wb_addr  out  5  latched rd.
- wb_data  out  32  result; holds its value until the next completion.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY on start=1 and kill=0. Acceptance edge latches funct3, rd, operand magnitudes, sign flags, and clears the 6-bit iteration counter. If kill=1 at the same time, start is ignored.
- BUSY: one iteration per edge.
  - Multiply: shift-add on 64-bit product.
  - Divide: restoring shift-subtract on 32-bit remainder.
- BUSY → DONE on the edge that completes iteration 32 (counter == 31). Final sign correction is applied on that same edge, and the result is written into wb_data.
- DONE → IDLE unconditionally on the next edge. A start in the DONE cycle is ignored.
- kill=1 in BUSY → IDLE on the next edge; done and wb_we are not asserted. kill in the DONE cycle is ignored, so the write-back still occurs.
- start while busy is ignored; inputs are not re-sampled.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Arithmetic works on magnitudes; the result is negated when required.
  - Product: negated when the operand signs differ.
  - Quotient: negated when the operand signs differ.
  - Remainder: takes the sign of the dividend.
- MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Special cases (RISC-V defined):
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = op_a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Both are detected at acceptance and override the iterative result.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, counter=0.
  - busy=0, done=0, wb_we=0, wb_addr=0, wb_data=0.
  - All internal registers are 0.
  - Reset mid-operation discards the operation; no write-back.
- Latency: start accepted at edge E0 → busy=1 after E0 → done=1 in the cycle after E32 → IDLE after E33. Total 33 cycles from acceptance to done.
- done, wb_we, wb_addr and wb_data are all registered outputs, valid for exactly one cycle, aligned with the register file's synchronous write edge.
- Minimum issue interval: 34 cycles (the next start is accepted at E34 at the earliest).

## Configuration
- MULDIV_EARLY_OUT_EN defined: divide-by-zero, signed overflow, and any multiply with a zero operand skip BUSY. IDLE → DONE at the acceptance edge, so done is asserted in the cycle after E0 (latency 1) and busy is high for that DONE cycle only.
- MULDIV_EARLY_OUT_EN undefined: every operation takes the full 33-cycle path. Special-case results are still overridden at the end.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD, rd=5 → done 33 cycles after acceptance, wb_we=1, wb_addr=5, wb_data=0xFFFFFFEB.
- High products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases:
  - DIV 9/0 → 0xFFFFFFFF; REM 9/0 → 9.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - done at latency 1 with MULDIV_EARLY_OUT_EN defined, 33 without.
- Abort and handshake:
  - kill asserted at BUSY iteration 10 → busy=0 next cycle, no done, no wb_we.
  - start pulses during BUSY and during DONE → ignored; a single completion only.
- Reset and rd=0:
  - rst pulsed asynchronously mid-BUSY → all outputs 0 immediately; the next start completes normally.
  - rd=0 → done=1, wb_we=0.
